bcd_updn_counter: RTL and testbench
===================================

BCD_UPDN_COUNTER -- requirements
Module: bcd_updn_counter

Interface
REQ-001 SHALL have parameter NDIG, default 2, number of BCD decades (legal 1..8).
REQ-002 SHALL have parameter RST_VAL, default 0, binary reset value of the counter, applied per decade as BCD (must be < 10^NDIG).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, count enable; one step per cycle while high.
REQ-006 SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-008 SHALL have port load_val, input, 4*NDIG, BCD value to load; decade 0 (units) in bits [3:0].
REQ-009 SHALL have port count, output, 4*NDIG, registered BCD count; same packing as load_val.
REQ-010 SHALL have port tc, output, 1, combinational terminal count: en & ~load & (up ? all decades 9 : all decades 0).
REQ-011 SHALL have port wrap, output, 1, registered one-cycle pulse marking a wrap event.
REQ-012 SHALL have port load_err, output, 1, registered one-cycle pulse marking an illegal load digit.

Function
REQ-013 SHALL give priority load > en; en is ignored in any cycle where load=1.
REQ-014 SHALL, on load, write load_val to count at the next edge, replacing any decade > 9 with 0 and pulsing load_err for that one cycle.
REQ-015 SHALL, on en & up, increment units; a decade at 9 becomes 0 and carries into the next decade in the same cycle (ripple carry is combinational, latency is one cycle).
REQ-016 SHALL, on en & ~up, decrement units; a decade at 0 becomes 9 and borrows from the next decade in the same cycle.
REQ-017 SHALL hold count when en=0 and load=0.
REQ-018 SHALL, when all decades are 9 and it counts up, wrap to all-0 and pulse wrap on the following cycle.
REQ-019 SHALL, when all decades are 0 and it counts down, wrap to all-9 and pulse wrap on the following cycle.
REQ-020 SHALL never present a decade value > 9 on count in any cycle.
REQ-021 SHALL allow up to change on any cycle; the new direction takes effect at that same edge.
REQ-022 SHALL keep wrap and load_err low in all cycles other than those specified.

Reset
REQ-023 SHALL, while rst_n=0, immediately force count to BCD(RST_VAL) and wrap and load_err to 0, independent of clk.
REQ-024 SHALL abort any in-progress load or count on reset; the first post-reset step occurs at the first rising edge with rst_n=1 and en or load high.

Configuration
REQ-025 SHALL, when BCD_CNT_SAT_EN is defined, saturate instead of wrapping: up at all-9 holds all-9, down at all-0 holds all-0, and wrap stays 0.
REQ-026 SHALL, when BCD_CNT_SAT_EN is undefined, wrap per REQ-018/REQ-019; tc behaves identically in both builds.

Structure
REQ-027 SHALL take the 4-bit BCD digit typedef and the constants BCD_MAX (9) and BCD_MIN (0) from the shared package bcd_pkg.
REQ-028 SHALL instantiate NDIG copies of sub-module bcd_digit (one decade: digit register, inc/dec, carry/borrow in and out, load with clamp) via a generate loop; the top level holds the wrap/load_err registers and tc logic.

Verification
REQ-029 SHALL cover: NDIG=2, reset, en=1 up=1 for 100 cycles -> count 00,01..99,00, wrap pulse exactly once, the cycle after 99->00.
REQ-030 SHALL cover: count=10, en=1 up=0 -> 09, then 08; at 00 -> 99 with wrap pulse.
REQ-031 SHALL cover: load=1 with load_val=0x5A and en=1 in the same cycle -> count=50, load_err=1 for one cycle, no count step.
REQ-032 SHALL cover: count=99, en=1 up=1 -> tc=1 in that cycle; with BCD_CNT_SAT_EN defined count stays 99 and wrap=0.
REQ-033 SHALL cover: rst_n driven low mid-count at count=47, asynchronous to clk -> count=RST_VAL immediately; wrap and load_err low.
REQ-034 SHALL cover: NDIG=4, load 0999, up=1 step -> 1000 in one cycle; down=0 step -> 0999.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, decade limits and a helper that
// extracts one decimal decade from a binary constant at elaboration time.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Decimal digit number idx (0 = units) of a binary value.
  function automatic bcd_digit_t bcd_decade(input int unsigned val, input int unsigned idx);
    int unsigned v;
    v = val;
    for (int unsigned k = 0; k < idx; k++) begin
      v = v / 10;
    end
    return bcd_digit_t'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: digit register with increment/decrement, carry/borrow
// chaining and a clamped parallel load (digits above 9 load as 0).
module bcd_digit
  import bcd_pkg::*;
#(
  parameter bcd_digit_t RST_DIGIT = BCD_MIN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_i,      // counter is stepping this cycle
  input  logic       up_i,        // 1 = increment, 0 = decrement
  input  logic       ci_i,        // carry (up) or borrow (down) from lower decade
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] digit_o,
  output logic       co_o,        // this decade rolls over when it steps
  output logic       bad_o        // load_val_i is not a legal BCD digit
);

  bcd_digit_t digit_q, digit_d;

  assign digit_o = digit_q;
  assign bad_o   = (load_val_i > BCD_MAX);
  // Carry/borrow chain is independent of step so the top can derive tc from it.
  assign co_o    = ci_i & (up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));

  // Next digit: load has priority, otherwise step only when the lower decades roll over.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = bad_o ? BCD_MIN : load_val_i;
    end else if (step_i && ci_i) begin
      if (up_i) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  // Digit register, asynchronously reset to this decade of the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= RST_DIGIT;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_updn_counter.sv
// Multi-decade BCD up/down counter with synchronous load, terminal count,
// wrap pulse and illegal-load pulse.
// Build option: define BCD_CNT_SAT_EN to saturate at all-9 / all-0 instead
// of wrapping (wrap then stays low; tc is unchanged).
module bcd_updn_counter
  import bcd_pkg::*;
#(
  parameter int          NDIG    = 2,
  parameter int unsigned RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] count,
  output logic              tc,
  output logic              wrap,
  output logic              load_err
);

  logic [NDIG:0]   carry;
  logic [NDIG-1:0] bad;
  logic            terminal;
  logic            step;
  logic            wrap_q, wrap_d;
  logic            load_err_q, load_err_d;

  // Units decade always sees a carry-in; the chain output marks all-9 (up) or all-0 (down).
  assign carry[0] = 1'b1;
  assign terminal = carry[NDIG];
  assign tc       = en & ~load & terminal;

`ifdef BCD_CNT_SAT_EN
  // Saturating build: suppress the step that would roll the whole counter over.
  assign step   = en & ~load & ~terminal;
  assign wrap_d = 1'b0;
`else
  assign step   = en & ~load;
  assign wrap_d = tc;
`endif

  assign load_err_d = load & (|bad);

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit #(
      .RST_DIGIT (bcd_decade(RST_VAL, g))
    ) u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_i     (step),
      .up_i       (up),
      .ci_i       (carry[g]),
      .load_i     (load),
      .load_val_i (load_val[4*g +: 4]),
      .digit_o    (count[4*g +: 4]),
      .co_o       (carry[g+1]),
      .bad_o      (bad[g])
    );
  end

  // One-cycle status pulses registered alongside the count update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updn_counter.sv
// Directed bench for bcd_updn_counter: a 2-decade instance (reset 00) driven
// from a vector table plus corner sequences, and a 4-decade instance (reset 1234).
module tb_bcd_updn_counter;

`ifdef BCD_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, up = 1'b0, load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  count;
  logic        tc, wrap, load_err;
  logic        en4 = 1'b0, up4 = 1'b0, load4 = 1'b0;
  logic [15:0] load_val4 = 16'h0000;
  logic [15:0] count4;
  logic        tc4, wrap4, load_err4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_updn_counter #(.NDIG(2), .RST_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  bcd_updn_counter #(.NDIG(4), .RST_VAL(1234)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .up(up4), .load(load4), .load_val(load_val4),
    .count(count4), .tc(tc4), .wrap(wrap4), .load_err(load_err4)
  );

  typedef struct {
    logic       ld;
    logic       e;
    logic       u;
    logic [7:0] lv;
    logic       x_tc;
    logic [7:0] x_cnt;
    logic       x_wrap;
    logic       x_lerr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ld, input logic e, input logic u, input logic [7:0] lv,
                     input logic x_tc, input logic [7:0] x_cnt, input logic x_wrap,
                     input logic x_lerr);
    vec_t v;
    v.ld = ld; v.e = e; v.u = u; v.lv = lv;
    v.x_tc = x_tc; v.x_cnt = x_cnt; v.x_wrap = x_wrap; v.x_lerr = x_lerr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic drive(input logic ld, input logic e, input logic u, input logic [7:0] lv);
    @(negedge clk);
    load = ld; en = e; up = u; load_val = lv;
  endtask

  task automatic drive4(input logic ld, input logic e, input logic u, input logic [15:0] lv);
    @(negedge clk);
    load4 = ld; en4 = e; up4 = u; load_val4 = lv;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_count", count, 8'h00);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_lerr", load_err, 1'b0);
    chk("rst_tc", tc, 1'b0);
    chk("rst_count4", count4, 16'h1234);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: ld, en, up, load_val | tc, count after edge, wrap, load_err
    add(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h50, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h51, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, SAT ? 8'h99 : 8'h00, !SAT, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, SAT ? 8'h00 : 8'h99, !SAT, 1'b0);
    add(1'b1, 1'b1, 1'b1, 8'hA9, 1'b0, 8'h09, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h98, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'h49, 1'b0, 8'h49, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h49, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ld, vq[i].e, vq[i].u, vq[i].lv);
      #1;
      chk($sformatf("vec%0d_tc", i), tc, vq[i].x_tc);
      edge_sample();
      chk($sformatf("vec%0d_count", i), count, vq[i].x_cnt);
      chk($sformatf("vec%0d_wrap", i), wrap, vq[i].x_wrap);
      chk($sformatf("vec%0d_lerr", i), load_err, vq[i].x_lerr);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Full up-count from reset: 00 -> 01 .. 99 -> 00, wrap only after 99 -> 00
    #1 rst_n = 1'b0;
    #1 chk("seqA_rst_count", count, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      edge_sample();
      chk($sformatf("seqA_count%0d", i), count,
          SAT ? to_bcd2((i + 1 > 99) ? 99 : i + 1) : to_bcd2((i + 1) % 100));
      chk($sformatf("seqA_wrap%0d", i), wrap, (!SAT && i == 99));
    end
    edge_sample();
    chk("seqA_after_count", count, SAT ? 8'h99 : 8'h01);
    chk("seqA_after_wrap", wrap, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-count at 47
    drive(1'b1, 1'b0, 1'b0, 8'h45);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    edge_sample();
    edge_sample();
    chk("seqB_count47", count, 8'h47);
    #2 rst_n = 1'b0;
    #1;
    chk("seqB_rst_count", count, 8'h00);
    chk("seqB_rst_wrap", wrap, 1'b0);
    chk("seqB_rst_lerr", load_err, 1'b0);
    chk("seqB_rst_count4", count4, 16'h1234);
    edge_sample();
    chk("seqB_hold_count", count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    edge_sample();
    chk("seqB_first_step", count, 8'h01);

    // Reset clears a live load_err pulse
    drive(1'b1, 1'b0, 1'b0, 8'h5A);
    edge_sample();
    chk("seqB_lerr_set", load_err, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("seqB_lerr_clr", load_err, 1'b0);
    chk("seqB_lerr_count", count, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;

    // Reset clears a live wrap pulse
    drive(1'b1, 1'b0, 1'b0, 8'h99);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    edge_sample();
    chk("seqB_wrap_set", wrap, !SAT);
    #2 rst_n = 1'b0;
    #1;
    chk("seqB_wrap_clr", wrap, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    edge_sample();
    chk("seqB_idle_count", count, 8'h00);

    // Four-decade carry/borrow ripple and wrap
    drive4(1'b1, 1'b0, 1'b0, 16'h0999);
    edge_sample();
    chk("seqC_load", count4, 16'h0999);
    drive4(1'b0, 1'b1, 1'b1, 16'h0000);
    edge_sample();
    chk("seqC_up", count4, 16'h1000);
    drive4(1'b0, 1'b1, 1'b0, 16'h0000);
    edge_sample();
    chk("seqC_down", count4, 16'h0999);
    drive4(1'b1, 1'b0, 1'b0, 16'h9999);
    edge_sample();
    drive4(1'b0, 1'b1, 1'b1, 16'h0000);
    #1 chk("seqC_tc_up", tc4, 1'b1);
    edge_sample();
    chk("seqC_wrap_up_count", count4, SAT ? 16'h9999 : 16'h0000);
    chk("seqC_wrap_up_pulse", wrap4, !SAT);
    drive4(1'b1, 1'b0, 1'b0, 16'h0000);
    edge_sample();
    chk("seqC_wrap_clear", wrap4, 1'b0);
    drive4(1'b0, 1'b1, 1'b0, 16'h0000);
    #1 chk("seqC_tc_down", tc4, 1'b1);
    edge_sample();
    chk("seqC_wrap_dn_count", count4, SAT ? 16'h0000 : 16'h9999);
    chk("seqC_wrap_dn_pulse", wrap4, !SAT);
    drive4(1'b1, 1'b1, 1'b1, 16'h12A4);
    edge_sample();
    chk("seqC_clamp_count", count4, 16'h1204);
    chk("seqC_clamp_lerr", load_err4, 1'b1);
    drive4(1'b0, 1'b0, 1'b0, 16'h0000);
    edge_sample();
    chk("seqC_lerr_pulse_end", load_err4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
